// File: rtl/sm_color_pkg.sv
// Shared types and constants for the colour-detect front end of the LED path.
package sm_color_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SET_R,
        CNT_R,
        SET_G,
        CNT_G,
        SET_B,
        CNT_B,
        DECIDE
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        RED,
        GREEN,
        BLUE
    } colour_e;

    // Filter select codes as {s2, s3}; the clear filter (10) is never used.
    localparam logic [1:0] FILT_R = 2'b00;
    localparam logic [1:0] FILT_G = 2'b11;
    localparam logic [1:0] FILT_B = 2'b01;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sm_edge_sync.sv
// Two-flop synchronizer followed by a single-cycle rising-edge pulse.
module sm_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/sm_color_detect.sv
// Scans the R/G/B sensor filters, counts sensor edges per window and pulses
// the dominant colour once it has won CONFIRM consecutive rounds.
module sm_color_detect
    import sm_color_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 500000,
    parameter int unsigned SETTLE_CYCLES = 5000,
    parameter int unsigned THRESHOLD     = 40,
    parameter int unsigned CONFIRM       = 2
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic en,
    input  logic sensor_out,
    output logic s2,
    output logic s3,
    output logic red,
    output logic green,
    output logic blue,
    output logic busy
);

    localparam logic [31:0]      SET_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]      WIN_LAST  = 32'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] THR       = CNT_W'(THRESHOLD);
    localparam logic [7:0]       CONFIRM_C = 8'(CONFIRM);

    state_e           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic [1:0]       filt_q, filt_d;
    logic [CNT_W-1:0] cnt_r_q, cnt_r_d;
    logic [CNT_W-1:0] cnt_g_q, cnt_g_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    colour_e          prev_q, prev_d;
    logic [7:0]       conf_q, conf_d;
    logic [2:0]       pulse_q, pulse_d;

    logic        rise;
    logic [31:0] phase_last;
    logic        phase_done;
    colour_e     winner;

    sm_edge_sync u_sync (
        .clk_i  (clk_50),
        .rst_ni (rst_n),
        .async_i(sensor_out),
        .rise_o (rise)
    );

    function automatic colour_e pick_winner(input logic [CNT_W-1:0] r,
                                            input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b);
        if (r >= THR && r > g && r > b) return RED;
        if (g >= THR && g > r && g > b) return GREEN;
        if (b >= THR && b > r && b > g) return BLUE;
        return NONE;
    endfunction

    assign winner = pick_winner(cnt_r_q, cnt_g_q, cnt_b_q);

    always_comb begin
        phase_last = '0;
        case (state_q)
            SET_R, SET_G, SET_B: phase_last = SET_LAST;
            CNT_R, CNT_G, CNT_B: phase_last = WIN_LAST;
            default:             phase_last = '0;
        endcase
    end

    assign phase_done = (timer_q == phase_last);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        filt_d  = filt_q;
        cnt_r_d = cnt_r_q;
        cnt_g_d = cnt_g_q;
        cnt_b_d = cnt_b_q;
        prev_d  = prev_q;
        conf_d  = conf_q;
        pulse_d = '0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (en) state_d = SET_R;
            end
            SET_R: if (phase_done) state_d = CNT_R;
            CNT_R: begin
                if (rise) cnt_r_d = sat_inc(cnt_r_q);
                if (phase_done) state_d = SET_G;
            end
            SET_G: if (phase_done) state_d = CNT_G;
            CNT_G: begin
                if (rise) cnt_g_d = sat_inc(cnt_g_q);
                if (phase_done) state_d = SET_B;
            end
            SET_B: if (phase_done) state_d = CNT_B;
            CNT_B: begin
                if (rise) cnt_b_d = sat_inc(cnt_b_q);
                if (phase_done) state_d = DECIDE;
            end
            DECIDE: begin
                state_d = SET_R;
                prev_d  = winner;
                if (winner != NONE && winner == prev_q)
                    conf_d = (conf_q == 8'hFF) ? conf_q : conf_q + 8'd1;
                else
                    conf_d = (winner == NONE) ? 8'd0 : 8'd1;
                if (winner != NONE && conf_d == CONFIRM_C)
                    pulse_d = {winner == RED, winner == GREEN, winner == BLUE};
            end
            default: state_d = IDLE;
        endcase

        // Phase entry actions: restart the timer, drive the filter, clear the count.
        if (state_d != state_q) begin
            timer_d = '0;
            case (state_d)
                SET_R:   filt_d  = FILT_R;
                SET_G:   filt_d  = FILT_G;
                SET_B:   filt_d  = FILT_B;
                CNT_R:   cnt_r_d = '0;
                CNT_G:   cnt_g_d = '0;
                CNT_B:   cnt_b_d = '0;
                default: ;
            endcase
        end

        if (state_q != IDLE && !en) begin
            state_d = IDLE;
            timer_d = '0;
            cnt_r_d = '0;
            cnt_g_d = '0;
            cnt_b_d = '0;
            prev_d  = NONE;
            conf_d  = '0;
            pulse_d = '0;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            filt_q  <= FILT_R;
            cnt_r_q <= '0;
            cnt_g_q <= '0;
            cnt_b_q <= '0;
            prev_q  <= NONE;
            conf_q  <= '0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            filt_q  <= filt_d;
            cnt_r_q <= cnt_r_d;
            cnt_g_q <= cnt_g_d;
            cnt_b_q <= cnt_b_d;
            prev_q  <= prev_d;
            conf_q  <= conf_d;
            pulse_q <= pulse_d;
        end
    end

    assign s2    = filt_q[1];
    assign s3    = filt_q[0];
    assign red   = pulse_q[2];
    assign green = pulse_q[1];
    assign blue  = pulse_q[0];
    assign busy  = (state_q != IDLE);

endmodule
